proto_port_filter: RTL and testbench

Parametrised successor to the single-rule ingress filter. It sits in the AXI4-Stream datapath between the RX queues and the output port lookup. It classifies each packet on its first beat against NUM_RULES programmable (protocol, source-port-mask) rules and then either forwards it with a rewritten destination-port byte or discards it whole. Forwarded and dropped packets are counted.

---
 rtl/proto_port_filter_pkg.sv | 16 +
 rtl/fallthrough_small_fifo.sv | 66 ++++++
 rtl/proto_rule_match.sv | 37 +++
 rtl/proto_port_filter.sv | 215 +++++++++++++++++++++
 tb/tb_proto_port_filter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proto_port_filter_pkg.sv
// Shared types and field widths for the protocol/port ingress filter.
package proto_port_filter_pkg;

  // Packet-level filter states; encodings are fixed so they read the same in waves.
  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  localparam int PORT_W  = 8;   // source/destination port byte in tuser
  localparam int PROTO_W = 8;   // IPv4 protocol byte in first-beat tdata
  localparam int CNT_W   = 32;  // packet statistics counters
  localparam int IDX_W   = 4;   // wide enough for up to 16 rules

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is visible on dout in the
// cycle after it is written, without a read request.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 8,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int AW    = MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] NF_LVL   = CW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  // Pointer and occupancy update; writes to a full FIFO and reads of an empty one are ignored.
  always_comb begin
    do_wr    = wr_en && (count_q != FULL_LVL);
    do_rd    = rd_en && (count_q != '0);
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset flushes the FIFO by clearing pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  // NOTE: the data array is not reset; only valid entries are ever read, and omitting reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

  assign dout        = mem_q[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign nearly_full = (count_q >= NF_LVL);

endmodule

// File: rtl/proto_rule_match.sv
// Combinational priority matcher: the lowest-indexed enabled rule whose
// protocol equals the packet protocol and whose source mask overlaps the
// packet source port wins.
module proto_rule_match
  import proto_port_filter_pkg::*;
#(
  parameter int NUM_RULES = 4
) (
  input  logic [NUM_RULES-1:0]         rule_en,
  input  logic [PROTO_W*NUM_RULES-1:0] rule_proto,
  input  logic [PORT_W*NUM_RULES-1:0]  rule_src_mask,
  input  logic [PORT_W*NUM_RULES-1:0]  rule_dst,
  input  logic [PROTO_W-1:0]           proto,
  input  logic [PORT_W-1:0]            src_port,
  output logic                         hit,
  output logic [IDX_W-1:0]             idx,
  output logic [PORT_W-1:0]            dst
);

  // Scan from the highest index down so the lowest matching rule is written last.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    hit = 1'b0;
    idx = '0;
    dst = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (rule_en[i] &&
          (rule_proto[PROTO_W*i +: PROTO_W] == proto) &&
          ((rule_src_mask[PORT_W*i +: PORT_W] & src_port) != '0)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
        dst = rule_dst[PORT_W*i +: PORT_W];
      end
    end
  end

endmodule

// File: rtl/proto_port_filter.sv
// Ingress filter: classifies each packet on its first beat against a set of
// (protocol, source-port-mask) rules, then forwards it with a rewritten
// destination-port byte or discards it whole, counting both outcomes.
module proto_port_filter
  import proto_port_filter_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24,
  parameter int PROTO_POS            = 184,
  parameter int NUM_RULES            = 4,
  parameter int FIFO_DEPTH_BITS      = 2
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  input  logic [NUM_RULES-1:0]                 cfg_rule_en,
  input  logic [8*NUM_RULES-1:0]               cfg_rule_proto,
  input  logic [8*NUM_RULES-1:0]               cfg_rule_src_mask,
  input  logic [8*NUM_RULES-1:0]               cfg_rule_dst,
  input  logic                                 cfg_default_drop,
  output logic [31:0]                          stat_fwd_pkts,
  output logic [31:0]                          stat_drop_pkts
);

  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int FIFO_W = C_S_AXIS_DATA_WIDTH + KEEP_W + C_S_AXIS_TUSER_WIDTH + 1;

  // FIFO head beat
  logic [FIFO_W-1:0]               fifo_dout;
  logic                            fifo_empty, fifo_nearly_full, fifo_wr, fifo_rd;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  head_data;
  logic [KEEP_W-1:0]               head_keep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] head_user;
  logic                            head_last;

  // Rule lookup on the head beat
  logic                match_hit;
  logic [IDX_W-1:0]    match_idx;
  logic [PORT_W-1:0]   match_dst;

  // Filter state and the per-packet action latched at the header
  state_e              state_q, state_d;
  logic                act_drop_q, act_drop_d;
  logic                act_rw_q, act_rw_d;
  logic [PORT_W-1:0]   dst_q, dst_d;
  logic                hold_q, hold_d;
  logic [CNT_W-1:0]    stat_fwd_q, stat_fwd_d;
  logic [CNT_W-1:0]    stat_drop_q, stat_drop_d;

  // Action in effect this cycle and handshake events
  logic                use_drop, use_rw;
  logic [PORT_W-1:0]   use_dst;
  logic                out_valid, fwd_done, drop_done;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] user_out;

  assign s_axis_tready = !fifo_nearly_full;
  assign fifo_wr       = s_axis_tvalid && s_axis_tready;

  fallthrough_small_fifo #(
    .WIDTH          (FIFO_W),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_in_fifo (
    .clk         (axis_aclk),
    .rst_n       (axis_resetn),
    .din         ({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
    .wr_en       (fifo_wr),
    .rd_en       (fifo_rd),
    .dout        (fifo_dout),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty)
  );

  assign {head_last, head_user, head_keep, head_data} = fifo_dout;

  proto_rule_match #(
    .NUM_RULES (NUM_RULES)
  ) u_match (
    .rule_en       (cfg_rule_en),
    .rule_proto    (cfg_rule_proto),
    .rule_src_mask (cfg_rule_src_mask),
    .rule_dst      (cfg_rule_dst),
    .proto         (head_data[PROTO_POS +: PROTO_W]),
    .src_port      (head_user[SRC_PORT_POS +: PORT_W]),
    .hit           (match_hit),
    .idx           (match_idx),
    .dst           (match_dst)
  );

  // The matcher never reports an index beyond the configured rule count.
  always_comb begin
    assert (!match_hit || (int'(match_idx) < NUM_RULES));
  end

  // Next-state, pop and output-valid decisions. A stalled header beat locks
  // its action (hold) so a cfg change cannot retract or alter a presented beat.
  always_comb begin
    state_d    = state_q;
    act_drop_d = act_drop_q;
    act_rw_d   = act_rw_q;
    dst_d      = dst_q;
    hold_d     = hold_q;
    use_drop   = act_drop_q;
    use_rw     = act_rw_q;
    use_dst    = dst_q;
    fifo_rd    = 1'b0;
    out_valid  = 1'b0;
    fwd_done   = 1'b0;
    drop_done  = 1'b0;
    case (state_q)
      ST_HEADER: begin
        if (!hold_q) begin
          use_drop = !match_hit && cfg_default_drop;
          use_rw   = match_hit;
          use_dst  = match_dst;
        end
        if (!fifo_empty) begin
          act_drop_d = use_drop;
          act_rw_d   = use_rw;
          dst_d      = use_dst;
          if (use_drop) begin
            fifo_rd = 1'b1;
            hold_d  = 1'b0;
            if (head_last) drop_done = 1'b1;
            else           state_d   = ST_DISCARD;
          end else begin
            out_valid = 1'b1;
            if (m_axis_tready) begin
              fifo_rd = 1'b1;
              hold_d  = 1'b0;
              if (head_last) fwd_done = 1'b1;
              else           state_d  = ST_FORWARD;
            end else begin
              hold_d = 1'b1;
            end
          end
        end
      end
      ST_FORWARD: begin
        if (!fifo_empty) begin
          out_valid = 1'b1;
          if (m_axis_tready) begin
            fifo_rd = 1'b1;
            if (head_last) begin
              fwd_done = 1'b1;
              state_d  = ST_HEADER;
            end
          end
        end
      end
      ST_DISCARD: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          if (head_last) begin
            drop_done = 1'b1;
            state_d   = ST_HEADER;
          end
        end
      end
      default: state_d = ST_HEADER;
    endcase
    stat_fwd_d  = stat_fwd_q  + {{(CNT_W-1){1'b0}}, fwd_done};
    stat_drop_d = stat_drop_q + {{(CNT_W-1){1'b0}}, drop_done};
  end

  // Output stream: FIFO head with the destination byte applied, zeroed when not valid.
  always_comb begin
    user_out = head_user;
    if (use_rw) user_out[DST_PORT_POS +: PORT_W] = use_dst;
    m_axis_tvalid = out_valid;
    m_axis_tdata  = out_valid ? head_data : '0;
    m_axis_tkeep  = out_valid ? head_keep : '0;
    m_axis_tuser  = out_valid ? user_out  : '0;
    m_axis_tlast  = out_valid && head_last;
  end

  // Filter state, latched action and statistics counters.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q     <= ST_HEADER;
      act_drop_q  <= 1'b0;
      act_rw_q    <= 1'b0;
      dst_q       <= '0;
      hold_q      <= 1'b0;
      stat_fwd_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      state_q     <= state_d;
      act_drop_q  <= act_drop_d;
      act_rw_q    <= act_rw_d;
      dst_q       <= dst_d;
      hold_q      <= hold_d;
      stat_fwd_q  <= stat_fwd_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_fwd_pkts  = stat_fwd_q;
  assign stat_drop_pkts = stat_drop_q;

endmodule

// File: tb/tb_proto_port_filter.sv
// Self-checking bench for proto_port_filter: a table of single-packet
// classification cases, then stall, back-to-back and mid-packet reset sequences.
module tb_proto_port_filter;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;
  localparam int NR = 4;
  localparam int NV = 10;

  logic          axis_aclk = 1'b0;
  logic          axis_resetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic [NR-1:0]   cfg_rule_en = '0;
  logic [8*NR-1:0] cfg_rule_proto = '0;
  logic [8*NR-1:0] cfg_rule_src_mask = '0;
  logic [8*NR-1:0] cfg_rule_dst = '0;
  logic            cfg_default_drop = 1'b0;
  logic [31:0]     stat_fwd_pkts;
  logic [31:0]     stat_drop_pkts;

  always #5 axis_aclk = ~axis_aclk;

  proto_port_filter #(.NUM_RULES(NR)) dut (
    .axis_aclk         (axis_aclk),
    .axis_resetn       (axis_resetn),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tkeep      (s_axis_tkeep),
    .s_axis_tuser      (s_axis_tuser),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .cfg_rule_en       (cfg_rule_en),
    .cfg_rule_proto    (cfg_rule_proto),
    .cfg_rule_src_mask (cfg_rule_src_mask),
    .cfg_rule_dst      (cfg_rule_dst),
    .cfg_default_drop  (cfg_default_drop),
    .stat_fwd_pkts     (stat_fwd_pkts),
    .stat_drop_pkts    (stat_drop_pkts)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    logic [3:0]  en;
    logic [31:0] proto;
    logic [31:0] mask;
    logic [31:0] dst;
    logic        dflt;
    logic [7:0]  src;
    logic [7:0]  pr;
    int          len;
    logic        fwd;
    logic [7:0]  edst;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  int    rx_cnt = 0;
  int    stall_cnt = 0;
  int    exp_fwd = 0;
  int    exp_drop = 0;
  logic  stall_mode = 1'b0;
  logic  ready_val = 1'b1;
  beat_t exp_q[$];
  vec_t  vecs[NV];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t make_beat(input int id, input int k, input int len,
                                      input logic [7:0] src, input logic [7:0] pr);
    beat_t b;
    b.data = '0;
    b.data[63:0]    = {32'(id), 32'(k)};
    b.data[255:192] = {32'hCAFE0000 ^ 32'(id), 32'(k * 7)};
    b.data[191:184] = pr;
    b.keep = (k == len - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    b.user = '0;
    b.user[127:64] = {32'(id), 32'hA5A5_0000 ^ 32'(k)};
    b.user[31:24]  = 8'hEE;
    b.user[23:16]  = src;
    b.user[15:0]   = 16'(k);
    b.last = (k == len - 1);
    return b;
  endfunction

  function automatic vec_t mk(input logic [3:0] en, input logic [31:0] proto, input logic [31:0] mask,
                              input logic [31:0] dst, input logic dflt, input logic [7:0] src,
                              input logic [7:0] pr, input int len, input logic fwd, input logic [7:0] edst);
    vec_t v;
    v.en = en; v.proto = proto; v.mask = mask; v.dst = dst; v.dflt = dflt;
    v.src = src; v.pr = pr; v.len = len; v.fwd = fwd; v.edst = edst;
    return v;
  endfunction

  task automatic push_expected(input int id, input logic [7:0] src, input logic [7:0] pr,
                               input int len, input logic [7:0] dst);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b = make_beat(id, k, len, src, pr);
      b.user[31:24] = dst;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_beats(input int id, input logic [7:0] src, input logic [7:0] pr,
                            input int len, input logic with_last);
    beat_t b;
    logic  hs;
    int    guard;
    for (int k = 0; k < len; k++) begin
      b = make_beat(id, k, len, src, pr);
      @(negedge axis_aclk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b.data;
      s_axis_tkeep  = b.keep;
      s_axis_tuser  = b.user;
      s_axis_tlast  = b.last & with_last;
      #1;
      hs = s_axis_tready;
      guard = 0;
      while (!hs && guard < 200) begin
        stall_cnt++;
        @(posedge axis_aclk);
        #1;
        hs = s_axis_tready;
        guard++;
      end
      check("send_accept", hs, 1'b1);
      @(posedge axis_aclk);
    end
  endtask

  task automatic idle();
    @(negedge axis_aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic set_cfg(input vec_t v);
    @(negedge axis_aclk);
    cfg_rule_en       = v.en;
    cfg_rule_proto    = v.proto;
    cfg_rule_src_mask = v.mask;
    cfg_rule_dst      = v.dst;
    cfg_default_drop  = v.dflt;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge axis_aclk);
      guard++;
    end
    repeat (5) @(posedge axis_aclk);
    check("drain_left", exp_q.size(), 0);
    @(negedge axis_aclk);
    check("idle_valid", m_axis_tvalid, 1'b0);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_fwd"},  stat_fwd_pkts,  exp_fwd);
    check({tag, "_drop"}, stat_drop_pkts, exp_drop);
  endtask

  // Downstream ready: constant or random, updated just after each rising edge.
  always @(posedge axis_aclk) begin
    #2;
    m_axis_tready = stall_mode ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Output monitor: scoreboard compare, hold-under-stall and zero-when-idle checks.
  beat_t mon_b, mon_e, prev_b;
  logic  prev_stall = 1'b0;
  always @(negedge axis_aclk) begin
    if (!axis_resetn) begin
      prev_stall = 1'b0;
    end else begin
      mon_b.data = m_axis_tdata;
      mon_b.keep = m_axis_tkeep;
      mon_b.user = m_axis_tuser;
      mon_b.last = m_axis_tlast;
      if (prev_stall) begin
        check("stall_valid", m_axis_tvalid, 1'b1);
        check("stall_data",  mon_b.data, prev_b.data);
        check("stall_user",  mon_b.user, prev_b.user);
        check("stall_last",  mon_b.last, prev_b.last);
      end
      if (!m_axis_tvalid)
        check("idle_zero", |{m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, 1'b0);
      if (m_axis_tvalid && m_axis_tready) begin
        rx_cnt++;
        check("beat_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("beat_data", mon_b.data, mon_e.data);
          check("beat_keep", mon_b.keep, mon_e.keep);
          check("beat_user", mon_b.user, mon_e.user);
          check("beat_last", mon_b.last, mon_e.last);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_b     = mon_b;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int guard;
    vec_t v;

    //            en       proto         mask          dst           dflt src    pr     len fwd edst
    vecs[0] = mk(4'b0001, 32'h00000001, 32'h00000001, 32'h00000004, 0, 8'h01, 8'h01, 3, 1, 8'h04);
    vecs[1] = mk(4'b0001, 32'h00000001, 32'h00000001, 32'h00000004, 1, 8'h04, 8'h01, 3, 0, 8'h00);
    vecs[2] = mk(4'b0001, 32'h00000001, 32'h00000001, 32'h00000004, 1, 8'h01, 8'h01, 2, 1, 8'h04);
    vecs[3] = mk(4'b0101, 32'h00060006, 32'h00FF00FF, 32'h00400010, 0, 8'h02, 8'h06, 2, 1, 8'h10);
    vecs[4] = mk(4'b0100, 32'h00060006, 32'h00FF00FF, 32'h00400010, 0, 8'h02, 8'h06, 2, 1, 8'h40);
    vecs[5] = mk(4'b0101, 32'h00060006, 32'h00FF00FF, 32'h00400010, 0, 8'h02, 8'h11, 2, 1, 8'hEE);
    vecs[6] = mk(4'b1010, 32'h11001100, 32'h80000100, 32'h83002100, 0, 8'h80, 8'h11, 3, 1, 8'h83);
    vecs[7] = mk(4'b1010, 32'h11001100, 32'h80000100, 32'h83002100, 1, 8'h81, 8'h11, 1, 1, 8'h21);
    vecs[8] = mk(4'b0001, 32'h00000001, 32'h00000001, 32'h00000004, 1, 8'h01, 8'h06, 1, 0, 8'h00);
    vecs[9] = mk(4'b0000, 32'h00000001, 32'h00000001, 32'h00000004, 1, 8'h01, 8'h01, 2, 0, 8'h00);

    // Reset state
    repeat (3) @(posedge axis_aclk);
    @(negedge axis_aclk);
    check("rst_tready", s_axis_tready, 1'b1);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_out_zero", |{m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, 1'b0);
    check_stats("rst");
    axis_resetn = 1'b1;
    repeat (2) @(posedge axis_aclk);

    // Table-driven single-packet classification
    for (int r = 0; r < NV; r++) begin
      set_cfg(vecs[r]);
      if (vecs[r].fwd) push_expected(r + 1, vecs[r].src, vecs[r].pr, vecs[r].len, vecs[r].edst);
      send_beats(r + 1, vecs[r].src, vecs[r].pr, vecs[r].len, 1'b1);
      idle();
      drain();
      if (vecs[r].fwd) exp_fwd++;
      else             exp_drop++;
      check_stats($sformatf("row%0d", r));
    end

    // Random stalls on a 5-beat packet with rule0 dst changed mid-packet
    v = mk(4'b0001, 32'h00000006, 32'h000000FF, 32'h00000010, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    set_cfg(v);
    stall_mode = 1'b1;
    base = rx_cnt;
    push_expected(50, 8'h08, 8'h06, 5, 8'h10);
    fork
      begin
        send_beats(50, 8'h08, 8'h06, 5, 1'b1);
        idle();
      end
      begin
        guard = 0;
        while (rx_cnt < base + 2 && guard < 300) begin
          @(posedge axis_aclk);
          guard++;
        end
        check("stall_progress", rx_cnt >= base + 2, 1'b1);
        @(posedge axis_aclk);
        #3;
        cfg_rule_dst[7:0] = 8'h77;
      end
    join
    drain();
    stall_mode = 1'b0;
    exp_fwd++;
    check("stall_beats", rx_cnt - base, 5);
    check_stats("stall");

    // 100 back-to-back single-beat packets, alternating forward and drop
    axis_resetn = 1'b0;
    @(negedge axis_aclk);
    axis_resetn = 1'b1;
    exp_fwd = 0;
    exp_drop = 0;
    v = mk(4'b0001, 32'h00000001, 32'h00000001, 32'h00000004, 1, 8'h00, 8'h00, 0, 0, 8'h00);
    set_cfg(v);
    stall_cnt = 0;
    for (int p = 0; p < 100; p++) begin
      if (p % 2 == 0) begin
        push_expected(100 + p, 8'h01, 8'h01, 1, 8'h04);
        send_beats(100 + p, 8'h01, 8'h01, 1, 1'b1);
      end else begin
        send_beats(100 + p, 8'h02, 8'h01, 1, 1'b1);
      end
    end
    idle();
    drain();
    exp_fwd = 50;
    exp_drop = 50;
    check("b2b_no_backpressure", stall_cnt, 0);
    check_stats("b2b");

    // Reset pulse mid-packet, then a fresh packet is classified from its first beat
    ready_val = 1'b0;
    repeat (2) @(posedge axis_aclk);
    send_beats(500, 8'h01, 8'h01, 2, 1'b0);
    idle();
    @(negedge axis_aclk);
    check("pre_rst_valid", m_axis_tvalid, 1'b1);
    #1;
    axis_resetn = 1'b0;
    #1;
    check("mid_rst_valid", m_axis_tvalid, 1'b0);
    check("mid_rst_out_zero", |{m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, 1'b0);
    check("mid_rst_tready", s_axis_tready, 1'b1);
    exp_fwd = 0;
    exp_drop = 0;
    check_stats("mid_rst");
    @(negedge axis_aclk);
    #1;
    axis_resetn = 1'b1;
    ready_val = 1'b1;
    repeat (2) @(posedge axis_aclk);
    push_expected(501, 8'h01, 8'h01, 2, 8'h04);
    send_beats(501, 8'h01, 8'h01, 2, 1'b1);
    idle();
    drain();
    exp_fwd = 1;
    check_stats("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
